// File: rtl/dft_fix2flt_pkg.sv
// Shared constants and float field layout for the fixed<->float conversion blocks.
package dft_fix2flt_pkg;
    localparam int IN_W       = 37;
    localparam int FRAC_W     = 34;
    localparam int EXP_W      = 8;
    localparam int MAN_W      = 23;
    localparam int EXP_BIAS   = 127;
    localparam int PIPE_DEPTH = 4;
    localparam int POS_W      = $clog2(IN_W);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float_t;
endpackage

// File: rtl/dft_fix37_to_float_e8m23_pipe_if.sv
// Sample/result bundle for the fixed-to-float converter; the inexact flag exists only
// when FIX2FLT_INEXACT_EN is defined.
interface dft_fix37_to_float_e8m23_pipe_if;
    import dft_fix2flt_pkg::*;

    logic             in_valid;
    logic [IN_W-1:0]  x;
    logic             out_valid;
    logic             a_sign;
    logic [EXP_W-1:0] a_exp;
    logic [MAN_W-1:0] a_man;
`ifdef FIX2FLT_INEXACT_EN
    logic             inexact;

    modport master (output in_valid, x, input out_valid, a_sign, a_exp, a_man, inexact);
    modport slave  (input in_valid, x, output out_valid, a_sign, a_exp, a_man, inexact);
`else
    modport master (output in_valid, x, input out_valid, a_sign, a_exp, a_man);
    modport slave  (input in_valid, x, output out_valid, a_sign, a_exp, a_man);
`endif
endinterface

// File: rtl/dft_lzd37.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module dft_lzd37
    import dft_fix2flt_pkg::*;
(
    input  logic [IN_W-1:0]  i_mag,
    output logic [POS_W-1:0] o_pos,
    output logic             o_zero
);
    // Ascending scan so the last hit (highest index) wins.
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (i_mag[i]) o_pos = POS_W'(i);
        end
    end

    assign o_zero = ~|i_mag;
endmodule

// File: rtl/dft_fix37_to_float_e8m23_pipe.sv
// Four-stage Q2.34 to IEEE-754 single converter (sign/mag, LZD, normalize+RNE, pack).
// Optional sticky/guard flag output enabled by FIX2FLT_INEXACT_EN.
module dft_fix37_to_float_e8m23_pipe
    import dft_fix2flt_pkg::*;
(
    input  logic                            aclk,
    input  logic                            areset_n,
    input  logic                            astall,
    dft_fix37_to_float_e8m23_pipe_if.slave  bus
);
    localparam logic [POS_W-1:0] TOP_POS = POS_W'(IN_W - 1);

    function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] frac,
                                                 input logic guard, input logic sticky);
        logic inc;
        inc = guard & (sticky | frac[0]);
        return {1'b0, frac} + (MAN_W+1)'(inc);
    endfunction

    function automatic float_t pack_float(input logic sign, input logic zero,
                                          input logic [POS_W-1:0] pos,
                                          input logic [MAN_W:0] rnd);
        float_t           f;
        logic [EXP_W:0]   e;
        e = (EXP_W+1)'(pos) + (EXP_W+1)'(EXP_BIAS - FRAC_W) + (EXP_W+1)'(rnd[MAN_W]);
        f.sign = sign;
        f.exp  = e[EXP_W-1:0];
        f.man  = rnd[MAN_W] ? '0 : rnd[MAN_W-1:0];
        if (zero) f = '0;
        return f;
    endfunction

    logic                    r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
    logic                    r_sign_p1, r_sign_p2, r_sign_p3;
    logic [IN_W-1:0]         r_mag_p1, r_mag_p2;
    logic                    r_zero_p2, r_zero_p3;
    logic [POS_W-1:0]        r_pos_p2, r_pos_p3;
    logic [MAN_W:0]          r_rnd_p3;
    float_t                  r_out_p4;

    logic signed [IN_W-1:0]  w_x_p0;
    logic [IN_W-1:0]         w_mag_p0;
    logic [POS_W-1:0]        w_pos_p1;
    logic                    w_zero_p1;
    logic [POS_W-1:0]        w_shift_p2;
    logic [IN_W-2:0]         w_norm_p2;
    logic [MAN_W-1:0]        w_frac_p2;
    logic                    w_guard_p2, w_sticky_p2;

    // ---- S1: sign / magnitude (negating -4.0 wraps to 2^36, which is the correct unsigned mag)
    assign w_x_p0   = $signed(bus.x);
    assign w_mag_p0 = w_x_p0[IN_W-1] ? $unsigned(-w_x_p0) : $unsigned(w_x_p0);

    // ---- S2: leading-one detect
    dft_lzd37 u_lzd (
        .i_mag  (r_mag_p1),
        .o_pos  (w_pos_p1),
        .o_zero (w_zero_p1)
    );

    // ---- S3: left-align so the leading one falls off the top as the hidden bit
    assign w_shift_p2  = TOP_POS - r_pos_p2;
    assign w_norm_p2   = (IN_W-1)'(r_mag_p2 << w_shift_p2);
    assign w_frac_p2   = w_norm_p2[IN_W-2 -: MAN_W];
    assign w_guard_p2  = w_norm_p2[IN_W-2-MAN_W];
    assign w_sticky_p2 = |w_norm_p2[IN_W-3-MAN_W:0];

    always_ff @(posedge aclk) begin
        if (!astall) begin
            if (bus.in_valid) begin
                r_sign_p1 <= bus.x[IN_W-1];
                r_mag_p1  <= w_mag_p0;
            end
            if (r_vld_p1) begin
                r_sign_p2 <= r_sign_p1;
                r_mag_p2  <= r_mag_p1;
                r_pos_p2  <= w_pos_p1;
                r_zero_p2 <= w_zero_p1;
            end
            if (r_vld_p2) begin
                r_sign_p3 <= r_sign_p2;
                r_zero_p3 <= r_zero_p2;
                r_pos_p3  <= r_pos_p2;
                r_rnd_p3  <= round_rne(w_frac_p2, w_guard_p2, w_sticky_p2);
            end
        end
    end

    // ---- S4: pack; valid chain and outputs are the only reset state
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_vld_p4 <= 1'b0;
            r_out_p4 <= '0;
        end else if (!astall) begin
            r_vld_p1 <= bus.in_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
            r_vld_p4 <= r_vld_p3;
            if (r_vld_p3) r_out_p4 <= pack_float(r_sign_p3, r_zero_p3, r_pos_p3, r_rnd_p3);
        end
    end

`ifdef FIX2FLT_INEXACT_EN
    logic r_inexact_p3, r_inexact_p4;

    always_ff @(posedge aclk) begin
        if (!astall && r_vld_p2) r_inexact_p3 <= w_guard_p2 | w_sticky_p2;
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_inexact_p4 <= 1'b0;
        end else if (!astall && r_vld_p3) begin
            r_inexact_p4 <= r_inexact_p3;
        end
    end

    assign bus.inexact = r_inexact_p4;
`endif

    assign bus.out_valid = r_vld_p4;
    assign bus.a_sign    = r_out_p4.sign;
    assign bus.a_exp     = r_out_p4.exp;
    assign bus.a_man     = r_out_p4.man;
endmodule

// File: tb/tb_dft_fix37_to_float_e8m23_pipe.sv
// Directed-vector bench for the fixed-to-float converter: table stream, latency,
// stall/bubble sequence and mid-flight reset.
module tb_dft_fix37_to_float_e8m23_pipe;
    logic aclk = 1'b0;
    logic areset_n;
    logic astall;

    dft_fix37_to_float_e8m23_pipe_if bus ();

    dft_fix37_to_float_e8m23_pipe dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .astall   (astall),
        .bus      (bus)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [36:0] x;
        logic        sign;
        logic [7:0]  e;
        logic [22:0] m;
        logic        inx;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];
    vec_t exp_q [$];
    logic vlog [$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge and scored against the queue.
    task automatic step();
        logic        stalled, in_rst;
        logic [32:0] snap;
        vec_t        e;
        stalled = astall;
        in_rst  = !areset_n;
        snap    = {bus.out_valid, bus.a_sign, bus.a_exp, bus.a_man};
        @(posedge aclk);
        #1;
        vlog.push_back(bus.out_valid);
        if (in_rst) return;
        if (stalled) begin
            chk("stall_hold", {31'd0, bus.out_valid, bus.a_sign, bus.a_exp, bus.a_man}, {31'd0, snap});
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                chk($sformatf("sign x=%h", e.x), 64'(bus.a_sign), 64'(e.sign));
                chk($sformatf("exp x=%h", e.x), 64'(bus.a_exp), 64'(e.e));
                chk($sformatf("man x=%h", e.x), 64'(bus.a_man), 64'(e.m));
`ifdef FIX2FLT_INEXACT_EN
                chk($sformatf("inexact x=%h", e.x), 64'(bus.inexact), 64'(e.inx));
`endif
            end
        end
    endtask

    task automatic cyc(input logic v, input int idx, input logic st);
        bus.in_valid = v;
        bus.x        = vt[idx].x;
        astall       = st;
        if (v && !st && areset_n) exp_q.push_back(vt[idx]);
        step();
    endtask

    initial begin
        int lat, first_v, last_v, zeros, out0;

        vt[0]  = '{37'h04_0000_0000, 1'b0, 8'd127, 23'h000000, 1'b0}; // 1.0
        vt[1]  = '{37'h1C_0000_0000, 1'b1, 8'd127, 23'h000000, 1'b0}; // -1.0
        vt[2]  = '{37'h02_0000_0000, 1'b0, 8'd126, 23'h000000, 1'b0}; // 0.5
        vt[3]  = '{37'h00_0000_0000, 1'b0, 8'd0,   23'h000000, 1'b0}; // 0
        vt[4]  = '{37'h10_0000_0000, 1'b1, 8'd129, 23'h000000, 1'b0}; // -4.0
        vt[5]  = '{37'h04_0000_0400, 1'b0, 8'd127, 23'h000000, 1'b1}; // tie, even
        vt[6]  = '{37'h04_0000_0C00, 1'b0, 8'd127, 23'h000002, 1'b1}; // tie, odd
        vt[7]  = '{37'h07_FFFF_FFFF, 1'b0, 8'd128, 23'h000000, 1'b1}; // carry-out
        vt[8]  = '{37'h00_0000_0001, 1'b0, 8'd93,  23'h000000, 1'b0}; // 2^-34
        vt[9]  = '{37'h1F_FFFF_FFFF, 1'b1, 8'd93,  23'h000000, 1'b0}; // -2^-34
        vt[10] = '{37'h06_0000_0000, 1'b0, 8'd127, 23'h400000, 1'b0}; // 1.5
        vt[11] = '{37'h1D_0000_0000, 1'b1, 8'd126, 23'h400000, 1'b0}; // -0.75
        vt[12] = '{37'h00_00AB_CDEF, 1'b0, 8'd116, 23'h2BCDEF, 1'b0}; // p=23, exact
        vt[13] = '{37'h04_0000_0401, 1'b0, 8'd127, 23'h000001, 1'b1}; // just above tie
        vt[14] = '{37'h0F_FFFF_FFFF, 1'b0, 8'd129, 23'h000000, 1'b1}; // max positive

        areset_n     = 1'b0;
        astall       = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        step();
        step();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset a_sign",    64'(bus.a_sign),    64'd0);
        chk("reset a_exp",     64'(bus.a_exp),     64'd0);
        chk("reset a_man",     64'(bus.a_man),     64'd0);
        areset_n = 1'b1;

        // Back-to-back table stream, then drain.
        for (int i = 0; i < NV; i++) cyc(1'b1, i, 1'b0);
        for (int i = 0; i < 6; i++)  cyc(1'b0, 0, 1'b0);
        chk("table outputs", 64'(n_out), 64'(NV));

        // Single-sample latency: edge of acceptance counts as cycle 1.
        cyc(1'b1, 0, 1'b0);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            cyc(1'b0, 0, 1'b0);
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0);

        // Stall for 3 cycles mid-stream with a junk sample presented, plus one bubble.
        vlog.delete();
        out0 = n_out;
        cyc(1'b1, 10, 1'b0);
        cyc(1'b1, 11, 1'b0);
        cyc(1'b1, 12, 1'b0);
        cyc(1'b1, 7, 1'b1);
        cyc(1'b1, 7, 1'b1);
        cyc(1'b1, 7, 1'b1);
        cyc(1'b1, 13, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 14, 1'b0);
        cyc(1'b1, 5, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b0);
        first_v = -1;
        last_v  = -1;
        for (int k = 0; k < vlog.size(); k++) begin
            if (vlog[k]) begin
                if (first_v < 0) first_v = k + 1;
                last_v = k + 1;
            end
        end
        zeros = 0;
        if (first_v > 0) begin
            for (int k = first_v; k < last_v; k++) if (!vlog[k - 1]) zeros++;
        end
        chk("stall first out step", 64'(first_v), 64'd7);
        chk("stall last out step",  64'(last_v),  64'd13);
        chk("stall bubble count",   64'(zeros),   64'd1);
        chk("stall outputs",        64'(n_out - out0), 64'd6);

        // Reset while 3 samples are in flight, with stall asserted at the same time.
        cyc(1'b1, 6, 1'b0);
        cyc(1'b1, 7, 1'b0);
        cyc(1'b1, 4, 1'b0);
        areset_n     = 1'b0;
        astall       = 1'b1;
        bus.in_valid = 1'b1;
        step();
        exp_q.delete();
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst a_sign",    64'(bus.a_sign),    64'd0);
        chk("midrst a_exp",     64'(bus.a_exp),     64'd0);
        chk("midrst a_man",     64'(bus.a_man),     64'd0);
        areset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 0, 1'b0);
            chk("no stale after reset", 64'(bus.out_valid), 64'd0);
        end

        // Pipeline still converts after the reset.
        out0 = n_out;
        cyc(1'b1, 11, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b0);
        chk("post-reset outputs", 64'(n_out - out0), 64'd1);
        chk("queue drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
